// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: single-cycle ALU plus an iterative multiply/divide
// unit, with valid/ready handshakes toward decode and toward writeback.
// ALU op encoding ({funct7[5], funct3}): 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT,
// 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND, 1001 pass B (LUI).
module ex_stage_mc #(
  parameter int WORD_WIDTH         = 32,
  parameter int ALU_OP_WIDTH       = 4,
  parameter int RISCV_M_CORE       = 1,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [WORD_WIDTH-1:0]   rdata1_i,
  input  logic [WORD_WIDTH-1:0]   rdata2_i,
  input  logic [WORD_WIDTH-1:0]   imm_i,
  input  logic [WORD_WIDTH-1:0]   pc_i,
  input  logic                    pc_alu_mux_i,
  input  logic                    imm_alu_mux_i,
  input  logic [ALU_OP_WIDTH-1:0] alu_op_ctrl_i,
  input  logic                    alu_mdu_sel_i,
  input  logic                    zeroflag_inv_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WORD_WIDTH-1:0]   ex_data_o,
  output logic [WORD_WIDTH-1:0]   rdata2_store_o,
  output logic                    branch_flag_o,
  output logic                    busy_o
);

  localparam int W         = WORD_WIDTH;
  localparam int BPC       = MUL_BITS_PER_CYCLE;
  localparam int SHW       = $clog2(W);
  localparam int CNT_W     = $clog2(W + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(W / BPC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             M_EN     = (RISCV_M_CORE != 0);

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'b1101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_PASSB = 4'b1001;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state_reg, state_next;

  logic             out_valid_reg;
  logic [W-1:0]     ex_data_reg, store_reg;
  logic             branch_reg;
  logic [2:0]       f3_reg;
  logic             neg_reg, rem_neg_reg, inv_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2*W-1:0]   mcand_reg, prod_reg;
  logic [W-1:0]     mplier_reg, divisor_reg, quot_reg, rem_reg;

  logic             accept, transfer, mdu_sel;
  logic [2:0]       funct3;
  logic [W-1:0]     op_a, op_b, a_mag, b_mag, alu_result;
  logic             a_neg, b_neg;

  assign mdu_sel     = alu_mdu_sel_i & M_EN;
  assign funct3      = alu_op_ctrl_i[2:0];
  assign op_a        = pc_alu_mux_i ? pc_i : rdata1_i;
  assign op_b        = imm_alu_mux_i ? imm_i : rdata2_i;
  assign in_ready_o  = (state_reg == IDLE) & (~out_valid_reg | out_ready_i) & ~flush_i;
  assign accept      = in_valid_i & in_ready_o;
  assign transfer    = out_valid_reg & out_ready_i;
  assign busy_o      = (state_reg == MUL) | (state_reg == DIV);
  assign out_valid_o = out_valid_reg;
  assign ex_data_o   = ex_data_reg;
  assign rdata2_store_o = store_reg;
  assign branch_flag_o  = branch_reg;

  // Operand signedness: rs1 signed for MULH/MULHSU/DIV/REM, rs2 signed for MULH/DIV/REM.
  assign a_neg = op_a[W-1] & ((funct3 == 3'd1) | (funct3 == 3'd2) | (funct3 == 3'd4) | (funct3 == 3'd6));
  assign b_neg = op_b[W-1] & ((funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6));
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // Single-cycle ALU
  always_comb begin
    alu_result = op_a + op_b;
    case (alu_op_ctrl_i)
      ALU_ADD:   alu_result = op_a + op_b;
      ALU_SUB:   alu_result = op_a - op_b;
      ALU_SLL:   alu_result = op_a << op_b[SHW-1:0];
      ALU_SLT:   alu_result = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_result = {{(W-1){1'b0}}, op_a < op_b};
      ALU_XOR:   alu_result = op_a ^ op_b;
      ALU_SRL:   alu_result = op_a >> op_b[SHW-1:0];
      ALU_SRA:   alu_result = W'($signed(op_a) >>> op_b[SHW-1:0]);
      ALU_OR:    alu_result = op_a | op_b;
      ALU_AND:   alu_result = op_a & op_b;
      ALU_PASSB: alu_result = op_b;
      default:   alu_result = op_a + op_b;
    endcase
  end

  // Multiplier: BPC partial products per cycle, one per retired multiplier bit
  logic [2*W-1:0] pp [BPC];
  logic [2*W-1:0] mul_add, prod_step, mul_full;
  logic [W-1:0]   mul_result;

  generate
    for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
      assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  // Sum the partial products and apply the final sign correction
  always_comb begin
    mul_add = '0;
    for (int i = 0; i < BPC; i++) mul_add = mul_add + pp[i];
    prod_step  = prod_reg + mul_add;
    mul_full   = neg_reg ? -prod_step : prod_step;
    mul_result = (f3_reg == 3'd0) ? mul_full[W-1:0] : mul_full[2*W-1:W];
  end

  // Restoring divider step and sign fix-up
  logic [W:0]   rem_shift;
  logic         div_ge;
  logic [W-1:0] rem_step, quot_step, div_result;

  always_comb begin
    rem_shift  = {rem_reg, quot_reg[W-1]};
    div_ge     = rem_shift >= {1'b0, divisor_reg};
    rem_step   = div_ge ? (rem_shift[W-1:0] - divisor_reg) : rem_shift[W-1:0];
    quot_step  = {quot_reg[W-2:0], div_ge};
    div_result = f3_reg[1] ? (rem_neg_reg ? -rem_reg : rem_reg)
                           : (neg_reg ? -quot_reg : quot_reg);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state: MDU ops iterate, then park in DONE until the result is taken
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept && mdu_sel) state_next = funct3[2] ? DIV : MUL;
      MUL:  if (cnt_reg == MUL_LAST) state_next = DONE;
      DIV:  if (cnt_reg == DIV_LAST) state_next = DONE;
      DONE: if (transfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  // Datapath: operand latch at accept, MDU iteration, result/valid registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_reg <= 1'b0;
      ex_data_reg   <= '0;
      store_reg     <= '0;
      branch_reg    <= 1'b0;
      f3_reg        <= '0;
      neg_reg       <= 1'b0;
      rem_neg_reg   <= 1'b0;
      inv_reg       <= 1'b0;
      cnt_reg       <= '0;
      mcand_reg     <= '0;
      prod_reg      <= '0;
      mplier_reg    <= '0;
      divisor_reg   <= '0;
      quot_reg      <= '0;
      rem_reg       <= '0;
    end else if (flush_i) begin
      out_valid_reg <= 1'b0;
    end else begin
      if (transfer) out_valid_reg <= 1'b0;
      if (accept) begin
        store_reg <= rdata2_i;
        f3_reg    <= funct3;
        inv_reg   <= zeroflag_inv_i;
        cnt_reg   <= '0;
        if (mdu_sel) begin
          mcand_reg   <= {{W{1'b0}}, a_mag};
          mplier_reg  <= b_mag;
          prod_reg    <= '0;
          divisor_reg <= b_mag;
          quot_reg    <= a_mag;
          rem_reg     <= '0;
          rem_neg_reg <= a_neg;
          // A zero divisor keeps the all-ones quotient unsigned-looking.
          neg_reg     <= funct3[2] ? ((a_neg ^ b_neg) & (op_b != '0)) : (a_neg ^ b_neg);
        end else begin
          ex_data_reg   <= alu_result;
          branch_reg    <= (alu_result == '0) ^ zeroflag_inv_i;
          out_valid_reg <= 1'b1;
        end
      end
      case (state_reg)
        MUL: begin
          prod_reg   <= prod_step;
          mcand_reg  <= mcand_reg << BPC;
          mplier_reg <= mplier_reg >> BPC;
          cnt_reg    <= cnt_reg + CNT_ONE;
          if (cnt_reg == MUL_LAST) begin
            ex_data_reg   <= mul_result;
            branch_reg    <= (mul_result == '0) ^ inv_reg;
            out_valid_reg <= 1'b1;
          end
        end
        DIV: begin
          cnt_reg <= cnt_reg + CNT_ONE;
          if (cnt_reg == DIV_LAST) begin
            ex_data_reg   <= div_result;
            branch_reg    <= (div_result == '0) ^ inv_reg;
            out_valid_reg <= 1'b1;
          end else begin
            rem_reg  <= rem_step;
            quot_reg <= quot_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: ALU ops, multiply/divide results and latency
// (two instances, 1 and 4 multiplier bits per cycle), reset, backpressure, flush.
module tb_ex_stage_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] rdata1 = '0, rdata2 = '0, imm = '0, pc = '0;
  logic        pc_mux = 1'b0, imm_mux = 1'b0;
  logic [3:0]  op = '0;
  logic        mdu = 1'b0, inv = 1'b0, flush = 1'b0, out_ready = 1'b1;

  logic        in_ready1, out_valid1, bf1, busy1;
  logic [31:0] ex_data1, store1;
  logic        in_ready4, out_valid4, bf4, busy4;
  logic [31:0] ex_data4, store4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage_mc #(.MUL_BITS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .rdata1_i(rdata1), .rdata2_i(rdata2), .imm_i(imm), .pc_i(pc),
    .pc_alu_mux_i(pc_mux), .imm_alu_mux_i(imm_mux), .alu_op_ctrl_i(op),
    .alu_mdu_sel_i(mdu), .zeroflag_inv_i(inv), .flush_i(flush),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .ex_data_o(ex_data1),
    .rdata2_store_o(store1), .branch_flag_o(bf1), .busy_o(busy1)
  );

  ex_stage_mc #(.MUL_BITS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
    .rdata1_i(rdata1), .rdata2_i(rdata2), .imm_i(imm), .pc_i(pc),
    .pc_alu_mux_i(pc_mux), .imm_alu_mux_i(imm_mux), .alu_op_ctrl_i(op),
    .alu_mdu_sel_i(mdu), .zeroflag_inv_i(inv), .flush_i(flush),
    .out_valid_o(out_valid4), .out_ready_i(out_ready), .ex_data_o(ex_data4),
    .rdata2_store_o(store4), .branch_flag_o(bf4), .busy_o(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle; returns just after its accept edge.
  task automatic send(input string tag, input logic [3:0] o, input logic m,
                      input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; op = o; mdu = m; rdata1 = a; rdata2 = b;
    #1;
    $display("txn %s op=%h mdu=%0d a=%08h b=%08h", tag, o, m, a, b);
    check({tag, " rdy"}, in_ready1, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  // Issue an MDU op and measure edges from accept to out_valid on both instances.
  task automatic run_mdu(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int lat1, input int lat4);
    int e, e4;
    logic [31:0] got4;
    e = 0; e4 = 0; got4 = '0;
    send(tag, {1'b0, f3}, 1'b1, a, b);
    while (!out_valid1 && e < 200) begin
      tick();
      e++;
      if (out_valid4 && e4 == 0) begin
        e4 = e;
        got4 = ex_data4;
      end
    end
    check({tag, " lat1"}, e, lat1);
    check({tag, " data1"}, ex_data1, exp);
    check({tag, " lat4"}, e4, lat4);
    check({tag, " data4"}, got4, exp);
    tick();   // transfer edge returns the stage to IDLE
  endtask

  typedef struct {
    string       tag;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        inv;
    logic [31:0] exp;
    logic        flag;
  } alu_vec_t;

  alu_vec_t av [7];
  int cnt;

  initial begin
    av[0] = '{"add",  4'b0000, 32'd5,        32'd7, 1'b0, 32'h0000000C, 1'b0};
    av[1] = '{"sub",  4'b1000, 32'd5,        32'd7, 1'b0, 32'hFFFFFFFE, 1'b0};
    av[2] = '{"slt",  4'b0010, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h00000001, 1'b0};
    av[3] = '{"sltu", 4'b0011, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h00000000, 1'b1};
    av[4] = '{"sra",  4'b1101, 32'h80000000, 32'd4, 1'b0, 32'hF8000000, 1'b0};
    av[5] = '{"beq",  4'b1000, 32'd9,        32'd9, 1'b0, 32'h00000000, 1'b1};
    av[6] = '{"bne",  4'b1000, 32'd9,        32'd9, 1'b1, 32'h00000000, 1'b0};

    // Reset values
    repeat (2) tick();
    check("rst valid", out_valid1, 1'b0);
    check("rst busy", busy1, 1'b0);
    check("rst data", ex_data1, 32'h0);
    check("rst store", store1, 32'h0);
    check("rst flag", bf1, 1'b0);
    rst = 1'b0;
    #1;
    check("rst ready", in_ready1, 1'b1);

    // Back-to-back ALU ops, one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; op = av[i].op; mdu = 1'b0; rdata1 = av[i].a; rdata2 = av[i].b;
      inv = av[i].inv;
      #1;
      $display("txn %s a=%08h b=%08h", av[i].tag, av[i].a, av[i].b);
      check({av[i].tag, " rdy"}, in_ready1, 1'b1);
      tick();
      check({av[i].tag, " valid"}, out_valid1, 1'b1);
      check({av[i].tag, " data"}, ex_data1, av[i].exp);
      check({av[i].tag, " flag"}, bf1, av[i].flag);
      check({av[i].tag, " store"}, store1, av[i].b);
    end
    in_valid = 1'b0; inv = 1'b0;
    tick();
    check("alu drain", out_valid1, 1'b0);

    // PC + immediate operand selection
    pc = 32'h00001000; imm = 32'h00000004; pc_mux = 1'b1; imm_mux = 1'b1;
    send("auipc", 4'b0000, 1'b0, 32'h0, 32'h0);
    check("auipc data", ex_data1, 32'h00001004);
    pc_mux = 1'b0; imm_mux = 1'b0;
    tick();

    // Multiply: 32 edges at 1 bit/cycle, 8 edges at 4 bits/cycle
    run_mdu("mulh",   3'd1, 32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFF, 32, 8);
    run_mdu("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, 8);
    run_mdu("mul",    3'd0, 32'h00010000, 32'h00010000, 32'h00000000, 32, 8);
    run_mdu("mulneg", 3'd0, 32'd3,        32'hFFFFFFFB, 32'hFFFFFFF1, 32, 8);
    run_mdu("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 8);

    // Divide: fixed 33 edges on both instances
    run_mdu("div0",   3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 33, 33);
    run_mdu("rem0",   3'd6, 32'd7,        32'd0,        32'h00000007, 33, 33);
    run_mdu("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 33);
    run_mdu("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 33);
    run_mdu("remneg", 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 33);
    run_mdu("divneg", 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 33);
    run_mdu("divu",   3'd5, 32'd100,      32'd7,        32'd14,       33, 33);
    run_mdu("remu",   3'd7, 32'd100,      32'd7,        32'd2,        33, 33);

    // Reset held for two cycles in the middle of a divide
    send("div_rst", 4'b0100, 1'b1, 32'd100, 32'd7);
    repeat (5) tick();
    check("mid busy", busy1, 1'b1);
    rst = 1'b1;
    repeat (2) tick();
    check("midrst valid", out_valid1, 1'b0);
    check("midrst busy", busy1, 1'b0);
    check("midrst data", ex_data1, 32'h0);
    rst = 1'b0;
    #1;
    check("midrst ready", in_ready1, 1'b1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid1) cnt++;
    end
    check("midrst novalid", cnt, 0);

    // Backpressure: result held, no accept until the transfer cycle
    out_ready = 1'b0;
    send("bp_add", 4'b0000, 1'b0, 32'd2, 32'd3);
    check("bp first", ex_data1, 32'd5);
    in_valid = 1'b1; op = 4'b0000; mdu = 1'b0; rdata1 = 32'd10; rdata2 = 32'd20;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp ready", in_ready1, 1'b0);
      check("bp valid", out_valid1, 1'b1);
      check("bp hold", ex_data1, 32'd5);
      check("bp store", store1, 32'd3);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp resume rdy", in_ready1, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp next data", ex_data1, 32'd30);
    check("bp next valid", out_valid1, 1'b1);
    tick();
    check("bp drain", out_valid1, 1'b0);

    // Flush during a divide, then a 1-cycle ADD
    send("div_flush", 4'b0100, 1'b1, 32'd100, 32'd7);
    repeat (9) tick();
    check("fl busy pre", busy1, 1'b1);
    flush = 1'b1;
    #1;
    check("fl ready", in_ready1, 1'b0);
    tick();
    flush = 1'b0;
    check("fl busy", busy1, 1'b0);
    check("fl valid", out_valid1, 1'b0);
    send("fl_add", 4'b0000, 1'b0, 32'd1, 32'd1);
    check("fl add valid", out_valid1, 1'b1);
    check("fl add data", ex_data1, 32'd2);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid1) cnt++;
    end
    check("fl novalid", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
